// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequencing slice: word format defaults,
// Q8.8 constants and the driver FSM state encoding.
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  // Q8.8 reference constants (1.0 and 0.5)
  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] Q_HALF = 16'h0080;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EVAL = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/lstm_seq_driver.sv
// Sequencer for the combinational LSTM cell: takes one xt per step, holds it
// with the registered h/c state in front of the cell, captures the cell's
// outputs after CELL_LAT cycles and streams each ht downstream.
module lstm_seq_driver
  import lstm_pkg::*;
#(
  parameter int  M           = 2,
  parameter int  N           = 4,
  parameter int  DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int  FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int  T_MAX       = 32,
  parameter int  CELL_LAT    = 1,
  localparam int LEN_W       = $clog2(T_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic                    clear_state,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [N*DATA_WIDTH-1:0] x_data,
  output logic [N*DATA_WIDTH-1:0] cell_xt,
  output logic [M*DATA_WIDTH-1:0] cell_htI,
  output logic [M*DATA_WIDTH-1:0] cell_ctI,
  input  logic [M*DATA_WIDTH-1:0] cell_htO,
  input  logic [M*DATA_WIDTH-1:0] cell_ctO,
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic [M*DATA_WIDTH-1:0] h_data,
  output logic                    h_last,
  output logic [M*DATA_WIDTH-1:0] c_final,
  output logic                    busy,
  output logic                    done
);

  localparam int               LAT_W    = $clog2(CELL_LAT + 1);
  localparam logic [LEN_W-1:0] T_MAX_L  = LEN_W'(T_MAX);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CELL_LAT - 1);

  // The cell needs at least one settle cycle; the word must keep an integer bit.
  if (CELL_LAT < 1 || FRACT_WIDTH >= DATA_WIDTH || T_MAX < 1) begin : g_bad_params
    $error("lstm_seq_driver: illegal parameter set");
  end

  seq_state_e              state_q, state_d;
  logic [N*DATA_WIDTH-1:0] x_q, x_d;
  logic [M*DATA_WIDTH-1:0] h_q, h_d;
  logic [M*DATA_WIDTH-1:0] c_q, c_d;
  logic [LEN_W-1:0]        step_q, step_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    done_q, done_d;
  logic                    x_ready_q, x_ready_d;
  logic                    h_valid_q, h_valid_d;
  logic                    h_last_q, h_last_d;
  logic                    busy_q, busy_d;

  // Next-state, datapath capture and registered-output decode
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    h_d     = h_q;
    c_d     = c_q;
    step_d  = step_q;
    len_d   = len_q;
    lat_d   = lat_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            len_d  = (seq_len > T_MAX_L) ? T_MAX_L : seq_len;
            step_d = '0;
            if (clear_state) begin
              h_d = '0;
              c_d = '0;
            end
            state_d = LOAD;
          end else begin
            // Empty sequence: acknowledge with done, leave h/c untouched
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (x_valid) begin
          x_d     = x_data;
          lat_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_LAST) begin
          h_d     = cell_htO;
          c_d     = cell_ctO;
          state_d = OUT;
        end
      end
      OUT: begin
        if (h_ready) begin
          if (step_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            step_d  = step_q + LEN_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    x_ready_d = (state_d == LOAD);
    h_valid_d = (state_d == OUT);
    h_last_d  = (state_d == OUT) && (step_d == len_d - LEN_W'(1));
    busy_d    = (state_d != IDLE);
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      h_q       <= '0;
      c_q       <= '0;
      step_q    <= '0;
      len_q     <= '0;
      lat_q     <= '0;
      done_q    <= 1'b0;
      x_ready_q <= 1'b0;
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      h_q       <= h_d;
      c_q       <= c_d;
      step_q    <= step_d;
      len_q     <= len_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      x_ready_q <= x_ready_d;
      h_valid_q <= h_valid_d;
      h_last_q  <= h_last_d;
      busy_q    <= busy_d;
    end
  end

  assign cell_xt  = x_q;
  assign cell_htI = h_q;
  assign cell_ctI = c_q;
  assign h_data   = h_q;
  assign c_final  = c_q;
  assign x_ready  = x_ready_q;
  assign h_valid  = h_valid_q;
  assign h_last   = h_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/lstm_seq_driver.md
Name: lstm_seq_driver

Overview:
Sequencer that drives the combinational lstm cell across a time sequence. It accepts xt vectors over a valid/ready stream and presents them to the cell with the registered hidden and cell state. After a fixed settle time it captures htO/ctO, feeds them back as htI/ctI for the next step, and streams each ht out over a valid/ready handshake. It is the controlling end of the cell's packed-vector interface and sits between the feature-column source and the CTC/classifier stage.

Parameters:
M, 2, hidden size (lanes in h/c)
N, 4, input size (lanes in xt)
DATA_WIDTH, 16, signed fixed-point word width
FRACT_WIDTH, 8, fractional bits (Q8.8 by default)
T_MAX, 32, maximum sequence length
CELL_LAT, 1, cycles the cell is given to settle before capture (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sequence when idle
seq_len  in  $clog2(T_MAX+1)  steps in sequence, sampled on start
clear_state  in  1  sampled on start; 1 = zero h/c before step 0
x_valid  in  1  input vector valid
x_ready  out  1  driver can accept xt
x_data  in  N*DATA_WIDTH  packed xt, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
cell_xt  out  N*DATA_WIDTH  to cell xt
cell_htI  out  M*DATA_WIDTH  to cell htI
cell_ctI  out  M*DATA_WIDTH  to cell ctI
cell_htO  in  M*DATA_WIDTH  from cell htO
cell_ctO  in  M*DATA_WIDTH  from cell ctO
h_valid  out  1  output ht valid
h_ready  in  1  downstream accepts ht
h_data  out  M*DATA_WIDTH  ht of current step
h_last  out  1  qualifies h_valid; final step of sequence
c_final  out  M*DATA_WIDTH  current c register; final ct after done
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse at sequence completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; x_reg, h_reg, c_reg, step, lat_cnt, len_reg = 0; all outputs 0. Reset mid-sequence aborts immediately; no done.
- cell_xt = x_reg, cell_htI = h_reg, cell_ctI = c_reg at all times (registered, glitch-free).
- IDLE: on start with seq_len != 0, latch len_reg = min(seq_len, T_MAX), set step = 0, zero h_reg/c_reg if clear_state, then go to LOAD. On start with seq_len == 0, pulse done next cycle and stay in IDLE; h/c are unchanged.
- LOAD: x_ready = 1. On x_valid && x_ready, x_reg <= x_data, lat_cnt <= 0, go to EVAL.
- EVAL: lat_cnt increments each cycle. In the cycle where lat_cnt == CELL_LAT-1, h_reg <= cell_htO, c_reg <= cell_ctO, go to OUT. Cell outputs are therefore sampled CELL_LAT cycles after x_reg updates.
- OUT: h_valid = 1, h_data = h_reg, h_last = (step == len_reg-1). Outputs are held stable until h_ready. On acceptance: if h_last, go to DONE; else step++ and go to LOAD.
- DONE: done = 1 for exactly one cycle, then return to IDLE. c_final = c_reg always; h_reg/c_reg persist for a later clear_state=0 run.
- x_ready is 0 outside LOAD; h_valid is 0 outside OUT; h_ready while h_valid=0 is ignored.
- start while busy is ignored; no restart or queueing.
- Minimum step period: CELL_LAT+2 cycles (LOAD, EVAL x CELL_LAT, OUT), with zero-wait handshakes.
- The block does no arithmetic; words pass through bit-exact, so there are no width changes or saturation.

Decomposition:
- Shared package lstm_pkg: DATA_WIDTH/FRACT_WIDTH defaults, Q8.8 constants (Q_ONE=16'h0100, Q_HALF=16'h0080), FSM state enum {IDLE, LOAD, EVAL, OUT, DONE}.
- No sub-module inside. The lstm cell stays external; a wrapper lstm_seq_top instantiates driver plus cell with weights wired directly.

Test Plan:
- Reset: hold rst_n=0 -> every output 0, x_ready=0, h_valid=0, busy=0. Release, idle 5 cycles -> unchanged.
- Basic run: bench stub cell htO[i]=htI[i]+xt[0], ctO[i]=ctI[i]+16'h0100. Use CELL_LAT=1, seq_len=3, clear_state=1, x lane0=16'h0080 each step, h_ready=1 -> h_data lanes 16'h0080, 16'h0100, 16'h0180; h_last only on third; c_final=16'h0300 per lane; done one cycle after third accept; step period 3 cycles.
- Backpressure: h_ready=0 for 5 cycles during OUT -> h_valid, h_data and h_last are stable and x_ready=0. Raise h_ready -> accepted in 1 cycle, then LOAD. x_valid withheld 4 cycles -> remain in LOAD.
- State carry: second run with seq_len=1, clear_state=0 after the basic run -> h_data=16'h0200, c_final=16'h0400. Repeat with clear_state=1 -> h_data=16'h0080.
- Edges: seq_len=0 -> done pulse, no h_valid. start during busy -> ignored. seq_len=40 with T_MAX=32 -> exactly 32 outputs. CELL_LAT=3 -> capture 3 cycles after x accept.
- Abort: rst_n low during EVAL of step 1 -> outputs 0 asynchronously, no done. A fresh start then runs correctly from zero state.
